branch_predict_resolve: RTL

Parametrised successor to the combinational branch comparator used in execute.
- Holds a branch history table (BHT) of saturating counters and answers fetch-stage direction lookups with a 1-cycle registered latency.
- Resolves conditional branches in execute and trains the BHT.
- Produces a registered outcome, a mispredict flag and the redirect PC for the fetch stage.

---
 rtl/branch_pkg.sv | 20 ++
 rtl/branch_predict_resolve_if.sv | 54 +++++
 rtl/branch_compare.sv | 36 +++
 rtl/branch_predict_resolve.sv | 127 ++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared branch definitions: funct3 encodings and BHT sizing helpers.
package branch_pkg;

   localparam logic [2:0] BEQ  = 3'b000;
   localparam logic [2:0] BNE  = 3'b001;
   localparam logic [2:0] BLT  = 3'b100;
   localparam logic [2:0] BGE  = 3'b101;
   localparam logic [2:0] BLTU = 3'b110;
   localparam logic [2:0] BGEU = 3'b111;

   // Weakly-not-taken value (0 for a 1-bit counter).
   function automatic int ctr_rst_val(input int w);
      return (1 << (w - 1)) - 1;
   endfunction

   function automatic int idx_width(input int n);
      return $clog2(n);
   endfunction

endpackage

// File: rtl/branch_predict_resolve_if.sv
// Fetch-lookup and execute-resolve bundle for branch_predict_resolve.
// Stats outputs exist only when BRANCH_STATS_EN is defined.
interface branch_predict_resolve_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  pred_valid;
   logic [DATA_WIDTH-1:0] pred_pc;
   logic                  pred_taken;
   logic                  pred_taken_valid;
   logic                  res_valid;
   logic [DATA_WIDTH-1:0] res_pc;
   logic [DATA_WIDTH-1:0] res_a;
   logic [DATA_WIDTH-1:0] res_b;
   logic [2:0]            res_funct3;
   logic [DATA_WIDTH-1:0] res_imm;
   logic                  res_pred_taken;
   logic                  out_valid;
   logic                  out_taken;
   logic                  out_mispredict;
   logic [DATA_WIDTH-1:0] out_redirect_pc;
   logic                  out_illegal;
`ifdef BRANCH_STATS_EN
   logic [31:0]           stat_branches;
   logic [31:0]           stat_mispredicts;

   modport master (
      output pred_valid, pred_pc, res_valid, res_pc, res_a, res_b,
             res_funct3, res_imm, res_pred_taken,
      input  pred_taken, pred_taken_valid, out_valid, out_taken,
             out_mispredict, out_redirect_pc, out_illegal,
             stat_branches, stat_mispredicts
   );
   modport slave (
      input  pred_valid, pred_pc, res_valid, res_pc, res_a, res_b,
             res_funct3, res_imm, res_pred_taken,
      output pred_taken, pred_taken_valid, out_valid, out_taken,
             out_mispredict, out_redirect_pc, out_illegal,
             stat_branches, stat_mispredicts
   );
`else
   modport master (
      output pred_valid, pred_pc, res_valid, res_pc, res_a, res_b,
             res_funct3, res_imm, res_pred_taken,
      input  pred_taken, pred_taken_valid, out_valid, out_taken,
             out_mispredict, out_redirect_pc, out_illegal
   );
   modport slave (
      input  pred_valid, pred_pc, res_valid, res_pc, res_a, res_b,
             res_funct3, res_imm, res_pred_taken,
      output pred_taken, pred_taken_valid, out_valid, out_taken,
             out_mispredict, out_redirect_pc, out_illegal
   );
`endif
endinterface

// File: rtl/branch_compare.sv
// Combinational branch condition evaluator.
module branch_compare
   import branch_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [DATA_WIDTH-1:0] i_a,
   input  logic [DATA_WIDTH-1:0] i_b,
   input  logic [2:0]            i_funct3,
   output logic                  o_taken,
   output logic                  o_illegal
);
   logic w_eq;
   logic w_lt;
   logic w_ltu;
   logic w_cond;

   assign w_eq  = (i_a == i_b);
   assign w_lt  = ($signed(i_a) < $signed(i_b));
   assign w_ltu = (i_a < i_b);

   always_comb begin
      w_cond    = 1'b0;
      o_illegal = 1'b0;
      unique case (1'b1)
         (i_funct3[2:1] == BEQ[2:1]):  w_cond = w_eq;
         (i_funct3[2:1] == BLT[2:1]):  w_cond = w_lt;
         (i_funct3[2:1] == BLTU[2:1]): w_cond = w_ltu;
         default:                      o_illegal = 1'b1;
      endcase
   end

   // funct3[0] selects the negated form of each comparison.
   assign o_taken = o_illegal ? 1'b0 : (w_cond ^ i_funct3[0]);

endmodule

// File: rtl/branch_predict_resolve.sv
// BHT direction predictor with execute-stage branch resolution and training.
// Optional BRANCH_STATS_EN adds saturating branch/mispredict counters.
module branch_predict_resolve
   import branch_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int BHT_ENTRIES = 64,
   parameter int CTR_WIDTH   = 2
) (
   input logic clk,
   input logic rst,
   branch_predict_resolve_if.slave bus
);
   localparam int IW = idx_width(BHT_ENTRIES);
   localparam logic [CTR_WIDTH-1:0] CTR_RST =
      CTR_WIDTH'(ctr_rst_val(CTR_WIDTH));
   localparam logic [CTR_WIDTH-1:0] CTR_MAX = '1;

   logic [CTR_WIDTH-1:0]  r_bht [BHT_ENTRIES];
   logic                  r_pred_taken;
   logic                  r_pred_taken_valid;
   logic                  r_out_valid;
   logic                  r_out_taken;
   logic                  r_out_mispredict;
   logic [DATA_WIDTH-1:0] r_out_redirect_pc;
   logic                  r_out_illegal;

   logic [IW-1:0]         w_res_idx;
   logic [IW-1:0]         w_pred_idx;
   logic                  w_taken;
   logic                  w_illegal;
   logic                  w_train;
   logic                  w_mispredict;
   logic [CTR_WIDTH-1:0]  w_ctr_cur;
   logic [CTR_WIDTH-1:0]  w_ctr_next;
   logic [CTR_WIDTH-1:0]  w_pred_ctr;
   logic [DATA_WIDTH-1:0] w_redirect;
   logic                  w_unused_pc;

   assign w_res_idx   = bus.res_pc[IW+1:2];
   assign w_pred_idx  = bus.pred_pc[IW+1:2];
   assign w_unused_pc = ^{bus.pred_pc[DATA_WIDTH-1:IW+2], bus.pred_pc[1:0]};

   branch_compare #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_cmp (
      .i_a       (bus.res_a),
      .i_b       (bus.res_b),
      .i_funct3  (bus.res_funct3),
      .o_taken   (w_taken),
      .o_illegal (w_illegal)
   );

   assign w_train      = bus.res_valid & ~w_illegal;
   assign w_mispredict = w_taken ^ bus.res_pred_taken;
   assign w_ctr_cur    = r_bht[w_res_idx];
   assign w_redirect   = bus.res_pc +
                         (w_taken ? bus.res_imm : DATA_WIDTH'(4));

   always_comb begin
      w_ctr_next = w_ctr_cur;
      if (w_taken && w_ctr_cur != CTR_MAX)
         w_ctr_next = w_ctr_cur + 1'b1;
      else if (!w_taken && w_ctr_cur != '0)
         w_ctr_next = w_ctr_cur - 1'b1;
   end

   // Write-first: a lookup colliding with a training write sees the new value.
   assign w_pred_ctr = (w_train && w_pred_idx == w_res_idx) ?
                       w_ctr_next : r_bht[w_pred_idx];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < BHT_ENTRIES; i++)
            r_bht[i] <= CTR_RST;
         r_pred_taken       <= 1'b0;
         r_pred_taken_valid <= 1'b0;
         r_out_valid        <= 1'b0;
         r_out_taken        <= 1'b0;
         r_out_mispredict   <= 1'b0;
         r_out_redirect_pc  <= '0;
         r_out_illegal      <= 1'b0;
      end else begin
         r_pred_taken_valid <= bus.pred_valid;
         if (bus.pred_valid)
            r_pred_taken <= w_pred_ctr[CTR_WIDTH-1];
         r_out_valid <= bus.res_valid;
         if (bus.res_valid) begin
            r_out_taken       <= w_taken;
            r_out_mispredict  <= w_mispredict;
            r_out_redirect_pc <= w_redirect;
            r_out_illegal     <= w_illegal;
         end
         if (w_train)
            r_bht[w_res_idx] <= w_ctr_next;
      end
   end

   assign bus.pred_taken       = r_pred_taken;
   assign bus.pred_taken_valid = r_pred_taken_valid;
   assign bus.out_valid        = r_out_valid;
   assign bus.out_taken        = r_out_taken;
   assign bus.out_mispredict   = r_out_mispredict;
   assign bus.out_redirect_pc  = r_out_redirect_pc;
   assign bus.out_illegal      = r_out_illegal;

`ifdef BRANCH_STATS_EN
   logic [31:0] r_stat_branches;
   logic [31:0] r_stat_mispredicts;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_stat_branches    <= '0;
         r_stat_mispredicts <= '0;
      end else if (bus.res_valid) begin
         if (!w_illegal && r_stat_branches != '1)
            r_stat_branches <= r_stat_branches + 1'b1;
         if (w_mispredict && r_stat_mispredicts != '1)
            r_stat_mispredicts <= r_stat_mispredicts + 1'b1;
      end
   end

   assign bus.stat_branches    = r_stat_branches;
   assign bus.stat_mispredicts = r_stat_mispredicts;
`endif

endmodule
